// File: rtl/bus_memory_responder.sv
// Memory-side responder for the eightbit CPU bus.
// Holds a 256x8 RAM, runs a clear-then-load boot sequence while holding the
// CPU, and maps one address onto a byte output port with a valid/ready
// handshake and a sticky overrun flag.
//
// Handshake semantics (both loader and IO port): a byte moves on a rising
// edge where valid && ready are both 1; valid is a level that the producer
// holds until that edge, and data must be stable while valid is 1.
module bus_memory_responder #(
    parameter logic [7:0] IO_ADDR    = 8'hFF,
    parameter int         INIT_CLEAR = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_data_out,
    input  logic       cpu_we,
    output logic [7:0] cpu_data_in,
    output logic       cpu_hold,
    input  logic       ld_valid,
    input  logic [7:0] ld_data,
    input  logic       ld_last,
    output logic       ld_ready,
    output logic [7:0] io_data,
    output logic       io_valid,
    input  logic       io_ready,
    output logic       io_overrun,
    output logic [1:0] o_dbg_state
);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t     r_state;
    logic [7:0] r_clr_addr;
    logic [7:0] r_ld_addr;
    logic [7:0] r_io_data;
    logic       r_io_valid;
    logic       r_io_overrun;
    logic [7:0] r_mem [256];

    logic       w_run;
    logic       w_ld_accept;
    logic       w_io_wr;
    logic       w_mem_we;
    logic [7:0] w_mem_addr;
    logic [7:0] w_mem_wdata;

    assign w_run       = (r_state == ST_RUN);
    assign w_ld_accept = (r_state == ST_LOAD) && ld_valid;
    assign w_io_wr     = w_run && cpu_we && (cpu_addr == IO_ADDR);

    // Select the single RAM write source for this cycle from the current state.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = 8'h00;
        w_mem_wdata = 8'h00;
        case (r_state)
            ST_CLEAR: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = r_clr_addr;
                w_mem_wdata = 8'h00;
            end
            ST_LOAD: begin
                w_mem_we    = ld_valid;
                w_mem_addr  = r_ld_addr;
                w_mem_wdata = ld_data;
            end
            ST_RUN: begin
                w_mem_we    = cpu_we && (cpu_addr != IO_ADDR);
                w_mem_addr  = cpu_addr;
                w_mem_wdata = cpu_data_out;
            end
            default: begin
                w_mem_we    = 1'b0;
            end
        endcase
    end

    // RAM write port; reset leaves contents alone and blocks writes on its edge.
    always_ff @(posedge clk) begin
        if (!rst && w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // Boot/run state machine plus the IO port registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_LOAD;
            r_clr_addr   <= 8'h00;
            r_ld_addr    <= 8'h00;
            r_io_data    <= 8'h00;
            r_io_valid   <= 1'b0;
            r_io_overrun <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_clr_addr <= r_clr_addr + 8'd1;
                    if (r_clr_addr == 8'hFF) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (w_ld_accept) begin
                        r_ld_addr <= r_ld_addr + 8'd1;
                        // Last byte, or the top address: never wrap into byte 0.
                        if (ld_last || (r_ld_addr == 8'hFF)) begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    r_state <= ST_RUN;
                end
                default: begin
                    r_state <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_LOAD;
                end
            endcase

            // A new IO write wins over a same-edge handshake, so valid stays up.
            if (w_io_wr) begin
                r_io_data  <= cpu_data_out;
                r_io_valid <= 1'b1;
                if (r_io_valid && !io_ready) begin
                    r_io_overrun <= 1'b1;
                end
            end else if (r_io_valid && io_ready) begin
                r_io_valid <= 1'b0;
            end
        end
    end

    // Asynchronous CPU read path; the IO address returns port status in RUN.
    always_comb begin
        if (!w_run) begin
            cpu_data_in = 8'h00;
        end else if (cpu_addr == IO_ADDR) begin
            cpu_data_in = {6'b0, r_io_overrun, r_io_valid};
        end else begin
            cpu_data_in = r_mem[cpu_addr];
        end
    end

    assign cpu_hold    = !w_run;
    assign ld_ready    = (r_state == ST_LOAD);
    assign io_data     = r_io_data;
    assign io_valid    = r_io_valid;
    assign io_overrun  = r_io_overrun;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bus_memory_responder.sv
// Directed bench for bus_memory_responder: boot clear/load sequencing,
// RUN-mode CPU reads/writes, the IO port handshake and resets mid-sequence.
module tb_bus_memory_responder;

  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;

  logic       clk;
  logic       rst;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_data_out;
  logic       cpu_we;
  logic [7:0] cpu_data_in;
  logic       cpu_hold;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_last;
  logic       ld_ready;
  logic [7:0] io_data;
  logic       io_valid;
  logic       io_ready;
  logic       io_overrun;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  bus_memory_responder #(.IO_ADDR(8'hFF), .INIT_CLEAR(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_addr     (cpu_addr),
    .cpu_data_out (cpu_data_out),
    .cpu_we       (cpu_we),
    .cpu_data_in  (cpu_data_in),
    .cpu_hold     (cpu_hold),
    .ld_valid     (ld_valid),
    .ld_data      (ld_data),
    .ld_last      (ld_last),
    .ld_ready     (ld_ready),
    .io_data      (io_data),
    .io_valid     (io_valid),
    .io_ready     (io_ready),
    .io_overrun   (io_overrun),
    .o_dbg_state  (dbg_state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // RUN-phase CPU vector: drive, clock once, then check outputs
  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       ior;
    logic [7:0] exp_rd;
    logic       exp_v;
    logic [7:0] exp_d;
    logic       exp_o;
  } vec_t;

  vec_t vecs[15];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic read_check(input string name, input logic [7:0] a, input logic [7:0] exp);
    cpu_addr = a;
    #1;
    check(name, cpu_data_in, exp);
  endtask

  task automatic drive_ld(input logic [7:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    ld_data  = 8'hEE;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cpu_addr = 8'h00; cpu_data_out = 8'h00; cpu_we = 1'b0;
    ld_valid = 1'b0; ld_data = 8'h00; ld_last = 1'b0; io_ready = 1'b0;

    vecs[0]  = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h01, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 8'h01, 8'h00, 1'b0, 8'hAA, 1'b0, 8'h00, 1'b0};
    vecs[2]  = '{1'b0, 8'h02, 8'h00, 1'b0, 8'h02, 1'b0, 8'h00, 1'b0};
    vecs[3]  = '{1'b0, 8'h20, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4]  = '{1'b1, 8'h10, 8'h5A, 1'b0, 8'h5A, 1'b0, 8'h00, 1'b0};
    vecs[5]  = '{1'b0, 8'h03, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[6]  = '{1'b1, 8'hFF, 8'h41, 1'b0, 8'h01, 1'b1, 8'h41, 1'b0};
    vecs[7]  = '{1'b1, 8'hFF, 8'h50, 1'b1, 8'h01, 1'b1, 8'h50, 1'b0};
    vecs[8]  = '{1'b1, 8'hFF, 8'h42, 1'b0, 8'h03, 1'b1, 8'h42, 1'b1};
    vecs[9]  = '{1'b0, 8'hFF, 8'h00, 1'b1, 8'h02, 1'b0, 8'h42, 1'b1};
    vecs[10] = '{1'b0, 8'hFF, 8'h00, 1'b0, 8'h02, 1'b0, 8'h42, 1'b1};
    vecs[11] = '{1'b1, 8'hFF, 8'h43, 1'b1, 8'h03, 1'b1, 8'h43, 1'b1};
    vecs[12] = '{1'b0, 8'h10, 8'h00, 1'b0, 8'h5A, 1'b1, 8'h43, 1'b1};
    vecs[13] = '{1'b1, 8'h11, 8'hC3, 1'b0, 8'hC3, 1'b1, 8'h43, 1'b1};
    vecs[14] = '{1'b0, 8'hFF, 8'h00, 1'b0, 8'h03, 1'b1, 8'h43, 1'b1};

    // reset then 256-cycle clear
    do_reset();
    check("rst_state", {6'b0, dbg_state}, {6'b0, S_CLEAR});
    check("rst_io_data", io_data, 8'h00);
    check("rst_io_valid", io_valid, 1'b0);
    check("rst_io_overrun", io_overrun, 1'b0);
    for (int i = 0; i < 256; i++) begin
      check("clear_ld_ready", ld_ready, 1'b0);
      check("clear_hold", cpu_hold, 1'b1);
      step();
    end
    check("clear_done_ld_ready", ld_ready, 1'b1);
    check("clear_done_state", {6'b0, dbg_state}, {6'b0, S_LOAD});

    // load three bytes with gaps; CPU write attempted while held
    cpu_we = 1'b1; cpu_addr = 8'h20; cpu_data_out = 8'h77;
    drive_ld(8'h01, 1'b0);
    check("load1_hold", cpu_hold, 1'b1);
    read_check("load_hold_read", 8'h00, 8'h00);
    cpu_addr = 8'h20;
    steps(2);
    drive_ld(8'hAA, 1'b0);
    check("load2_ld_ready", ld_ready, 1'b1);
    steps(2);
    drive_ld(8'h02, 1'b1);
    cpu_we = 1'b0;
    check("load_last_hold", cpu_hold, 1'b0);
    check("load_last_ld_ready", ld_ready, 1'b0);
    check("load_last_state", {6'b0, dbg_state}, {6'b0, S_RUN});

    // RAM beyond the loaded bytes reads as cleared
    for (int a = 3; a < 255; a++) read_check("cleared_byte", a[7:0], 8'h00);

    // RUN vectors: RAM writes, IO port handshake and overrun
    for (int i = 0; i < 15; i++) begin
      cpu_addr = vecs[i].addr; cpu_we = vecs[i].we;
      cpu_data_out = vecs[i].wdata; io_ready = vecs[i].ior;
      step();
      cpu_we = 1'b0; io_ready = 1'b0;
      check($sformatf("vec%0d_rd", i), cpu_data_in, vecs[i].exp_rd);
      check($sformatf("vec%0d_io_valid", i), io_valid, vecs[i].exp_v);
      check($sformatf("vec%0d_io_data", i), io_data, vecs[i].exp_d);
      check($sformatf("vec%0d_io_overrun", i), io_overrun, vecs[i].exp_o);
    end

    // reset in RUN with io_valid pending
    do_reset();
    check("rstrun_state", {6'b0, dbg_state}, {6'b0, S_CLEAR});
    check("rstrun_hold", cpu_hold, 1'b1);
    check("rstrun_io_valid", io_valid, 1'b0);
    check("rstrun_io_overrun", io_overrun, 1'b0);
    check("rstrun_io_data", io_data, 8'h00);
    read_check("rstrun_read", 8'h10, 8'h00);
    steps(256);
    check("rstrun_to_load", {6'b0, dbg_state}, {6'b0, S_LOAD});

    // full 256-byte load without ld_last
    for (int a = 0; a < 256; a++) begin
      check("full_hold", cpu_hold, 1'b1);
      ld_valid = 1'b1; ld_data = a[7:0] ^ 8'h55; ld_last = 1'b0;
      step();
    end
    ld_valid = 1'b0;
    check("full_state", {6'b0, dbg_state}, {6'b0, S_RUN});
    check("full_ld_ready", ld_ready, 1'b0);
    read_check("full_80", 8'h80, 8'hD5);
    read_check("full_00", 8'h00, 8'h55);
    read_check("full_10", 8'h10, 8'h45);
    read_check("full_11", 8'h11, 8'h44);
    read_check("full_fe", 8'hFE, 8'hAB);
    ld_valid = 1'b1; ld_data = 8'h12;
    steps(2);
    ld_valid = 1'b0;
    read_check("run_ignores_ld", 8'h00, 8'h55);

    // reset on the 5th LOAD byte restarts clear and the load address
    do_reset();
    steps(256);
    drive_ld(8'h11, 1'b0);
    drive_ld(8'h22, 1'b0);
    drive_ld(8'h33, 1'b0);
    drive_ld(8'h44, 1'b0);
    ld_valid = 1'b1; ld_data = 8'h55; rst = 1'b1;
    step();
    rst = 1'b0; ld_valid = 1'b0;
    check("rstload_state", {6'b0, dbg_state}, {6'b0, S_CLEAR});
    check("rstload_hold", cpu_hold, 1'b1);
    check("rstload_ld_ready", ld_ready, 1'b0);
    steps(256);
    drive_ld(8'h99, 1'b1);
    check("rstload_run", {6'b0, dbg_state}, {6'b0, S_RUN});
    read_check("rstload_00", 8'h00, 8'h99);
    read_check("rstload_01", 8'h01, 8'h00);
    read_check("rstload_04", 8'h04, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
